acc_postproc: RTL and testbench
===============================

// Module: acc_postproc
// PURPOSE
//  Downstream stage of the kernel accumulator. Takes each signed accumulated kernel sum, adds a
//  per-element bias, applies optional ReLU, requantises via rounded arithmetic right shift and
//  saturates to signed O_BW. Packs PACK results into one output word behind a valid/ready
//  handshake. Back-pressure propagates upstream through o_acc_ready.
// PARAMETERS
//  AK_BW    20  width of signed accumulator sum (i_acc_kernel)
//  B_BW     16  width of signed bias; B_BW <= AK_BW
//  O_BW      8  width of each signed requantised result
//  PACK      4  results per output word (power of 2, >= 2)
//  SH_BW     5  width of shift amount
// PORTS
//  clk           in   1              clock, all logic rising-edge
//  rst_n         in   1              synchronous reset, active-HIGH (name kept for codebase consistency)
//  i_acc_valid   in   1              i_acc_kernel/i_bias/i_shift/i_relu_en/i_last valid
//  o_acc_ready   out  1              stage accepts input this cycle
//  i_acc_kernel  in   AK_BW          signed accumulated sum
//  i_bias        in   B_BW           signed bias for this element
//  i_shift       in   SH_BW          right-shift amount, 0..AK_BW
//  i_relu_en     in   1              1: clamp negative sums to 0 before shift
//  i_last        in   1              element closes the current output word early
//  o_pack_valid  out  1              output word valid
//  i_pack_ready  in   1              downstream accepts word
//  o_pack_data   out  O_BW*PACK      packed results, lane 0 at LSBs; unfilled lanes = 0
//  o_pack_mask   out  PACK           1 per filled lane
//  o_sat_cnt     out  16             count of saturated elements, sticks at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst_n=1 at edge): o_pack_valid=0, o_pack_data=0, o_pack_mask=0, o_sat_cnt=0, lane
//    index=0, all pipeline valid bits=0. Partial word and in-flight elements are discarded.
//  - Global advance: adv = !o_pack_valid | i_pack_ready; o_acc_ready = adv (combinational).
//    Transfer on i_acc_valid & o_acc_ready. When adv=0 every stage holds its contents.
//  - S1 (register): sum = sext(i_acc_kernel) + sext(i_bias), AK_BW+1 bits; shift/relu/last carried.
//  - S2 (register): r = (relu_en & sum<0) ? 0 : sum; if shift>0 r = (r + 2^(shift-1)) >>> shift
//    (AK_BW+2-bit math, round half toward +inf); saturate to [-2^(O_BW-1), 2^(O_BW-1)-1];
//    sat flag = clamped value differed from the unsaturated value.
//  - S3 packer: result written to lane[idx], mask bit set, idx++. If idx reaches PACK-1 or last=1,
//    the word moves to the output register (o_pack_valid=1) and idx/lanes/mask clear in same cycle.
//  - Latency: element accepted at edge N appears in output word at edge N+3 (if it completes word).
//  - Output register holds data/mask stable while o_pack_valid & !i_pack_ready.
//  - Word handoff and i_pack_ready in same cycle: new word replaces old, valid stays 1, no bubble.
//  - i_last on lane PACK-1: single word, mask all ones (no empty extra word).
//  - o_sat_cnt increments once per element leaving S2 with sat flag and adv=1; holds at FFFF.
//  - i_shift > AK_BW: treated as AK_BW.
// TESTING
//  1 acc=100,bias=-4,shift=2,relu=0 (x4, last on 4th) -> data 0x18181818, mask 0xF, 3 cyc latency
//  2 acc=-300,bias=0,shift=0,relu=1 -> lane 0x00; acc=-6,shift=2,relu=0 -> lane 0xFF (-1)
//  3 acc=1000 then -1000, shift=0, relu=0, last on 2nd -> data 0x0000807F, mask 0x3, o_sat_cnt=2
//  4 values 1,2,3,4 back-to-back, i_pack_ready=0 for 5 cycles -> o_acc_ready=0 while held,
//    data 0x04030201 stable, no element lost or duplicated after i_pack_ready=1
//  5 two elements accepted, rst_n=1 for 1 cycle, then 4 elements 5..8 -> single word 0x08070605
//  6 random 1000 elements with random valid/ready stalls -> match reference model word-for-word

Source files
------------

// File: rtl/acc_postproc.sv
// acc_postproc: bias add, optional ReLU, rounded requantising shift, saturation and lane packing
// behind a valid/ready handshake whose stall freezes every stage.
`default_nettype none

module acc_postproc #(
  parameter int AK_BW = 20,
  parameter int B_BW  = 16,
  parameter int O_BW  = 8,
  parameter int PACK  = 4,
  parameter int SH_BW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_acc_valid,
  output logic                 o_acc_ready,
  input  logic [AK_BW-1:0]     i_acc_kernel,
  input  logic [B_BW-1:0]      i_bias,
  input  logic [SH_BW-1:0]     i_shift,
  input  logic                 i_relu_en,
  input  logic                 i_last,
  output logic                 o_pack_valid,
  input  logic                 i_pack_ready,
  output logic [O_BW*PACK-1:0] o_pack_data,
  output logic [PACK-1:0]      o_pack_mask,
  output logic [15:0]          o_sat_cnt
);

  localparam int c_SW = AK_BW + 1;
  localparam int c_RW = AK_BW + 2;
  localparam int c_IW = $clog2(PACK);
  localparam logic signed [c_RW-1:0] c_OMAX = c_RW'((1 << (O_BW - 1)) - 1);
  localparam logic signed [c_RW-1:0] c_OMIN = ~c_OMAX;

  logic w_adv;
  assign w_adv       = !o_pack_valid || i_pack_ready;
  assign o_acc_ready = w_adv;

  // S1: widened bias add
  logic signed [c_SW-1:0] w_s1_sum;
  assign w_s1_sum = $signed({i_acc_kernel[AK_BW-1], i_acc_kernel})
                  + $signed({{(c_SW-B_BW){i_bias[B_BW-1]}}, i_bias});

  logic                   r_s1_valid;
  logic signed [c_SW-1:0] r_s1_sum;
  logic [SH_BW-1:0]       r_s1_shift;
  logic                   r_s1_relu;
  logic                   r_s1_last;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_shift <= '0;
      r_s1_relu  <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= i_acc_valid;
      r_s1_sum   <= w_s1_sum;
      r_s1_shift <= i_shift;
      r_s1_relu  <= i_relu_en;
      r_s1_last  <= i_last;
    end
  end

  // S2: ReLU, round-half-up arithmetic shift, saturate
  logic [SH_BW-1:0]       w_sh;
  logic signed [c_RW-1:0] w_relu_val;
  logic signed [c_RW-1:0] w_round;
  logic signed [c_RW-1:0] w_shifted;
  logic                   w_sat;
  logic [O_BW-1:0]        w_res;

  assign w_sh       = (r_s1_shift > SH_BW'(AK_BW)) ? SH_BW'(AK_BW) : r_s1_shift;
  assign w_relu_val = (r_s1_relu && r_s1_sum[c_SW-1]) ? '0 : $signed({r_s1_sum[c_SW-1], r_s1_sum});
  assign w_round    = (w_sh == '0) ? '0 : $signed(c_RW'(1) << (w_sh - 1'b1));
  assign w_shifted  = (w_relu_val + w_round) >>> w_sh;
  assign w_sat      = (w_shifted > c_OMAX) || (w_shifted < c_OMIN);
  assign w_res      = (w_shifted > c_OMAX) ? c_OMAX[O_BW-1:0] :
                      (w_shifted < c_OMIN) ? c_OMIN[O_BW-1:0] : w_shifted[O_BW-1:0];

  logic            r_s2_valid;
  logic [O_BW-1:0] r_s2_res;
  logic            r_s2_sat;
  logic            r_s2_last;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_sat   <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_res   <= w_res;
      r_s2_sat   <= w_sat;
      r_s2_last  <= r_s1_last;
    end
  end

  logic            r_s3_valid;
  logic [O_BW-1:0] r_s3_res;
  logic            r_s3_last;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_res   <= '0;
      r_s3_last  <= 1'b0;
      o_sat_cnt  <= '0;
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      r_s3_res   <= r_s2_res;
      r_s3_last  <= r_s2_last;
      if (r_s2_valid && r_s2_sat && (o_sat_cnt != 16'hFFFF))
        o_sat_cnt <= o_sat_cnt + 16'd1;
    end
  end

  // Packer: the completing element goes straight into the output word
  logic [O_BW*PACK-1:0] r_lanes;
  logic [PACK-1:0]      r_mask;
  logic [c_IW-1:0]      r_idx;
  logic [O_BW*PACK-1:0] w_word;
  logic [PACK-1:0]      w_mask;
  logic                 w_done;

  always_comb begin
    w_word = r_lanes;
    w_mask = r_mask;
    for (int l = 0; l < PACK; l++) begin
      if (c_IW'(l) == r_idx) begin
        w_word[l*O_BW +: O_BW] = r_s3_res;
        w_mask[l]              = 1'b1;
      end
    end
  end

  assign w_done = r_s3_valid && (r_s3_last || (r_idx == c_IW'(PACK - 1)));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_lanes      <= '0;
      r_mask       <= '0;
      r_idx        <= '0;
      o_pack_valid <= 1'b0;
      o_pack_data  <= '0;
      o_pack_mask  <= '0;
    end else if (w_adv) begin
      if (w_done) begin
        o_pack_valid <= 1'b1;
        o_pack_data  <= w_word;
        o_pack_mask  <= w_mask;
        r_lanes      <= '0;
        r_mask       <= '0;
        r_idx        <= '0;
      end else begin
        o_pack_valid <= 1'b0;
        if (r_s3_valid) begin
          r_lanes <= w_word;
          r_mask  <= w_mask;
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_postproc.sv
// tb_acc_postproc: directed cases plus randomized traffic, scored against an arithmetic reference
// model through an expected-word queue popped by an independent output monitor.
`default_nettype none

module tb_acc_postproc;

  localparam int PACK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_acc_valid;
  logic        o_acc_ready;
  logic [19:0] i_acc_kernel;
  logic [15:0] i_bias;
  logic [4:0]  i_shift;
  logic        i_relu_en;
  logic        i_last;
  logic        o_pack_valid;
  logic        i_pack_ready;
  logic [31:0] o_pack_data;
  logic [3:0]  o_pack_mask;
  logic [15:0] o_sat_cnt;

  acc_postproc dut (
    .clk(clk), .rst_n(rst_n),
    .i_acc_valid(i_acc_valid), .o_acc_ready(o_acc_ready),
    .i_acc_kernel(i_acc_kernel), .i_bias(i_bias), .i_shift(i_shift),
    .i_relu_en(i_relu_en), .i_last(i_last),
    .o_pack_valid(o_pack_valid), .i_pack_ready(i_pack_ready),
    .o_pack_data(o_pack_data), .o_pack_mask(o_pack_mask), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_data[$];
  logic [3:0]  exp_mask[$];
  logic [31:0] m_word;
  logic [3:0]  m_mask;
  int          m_n;
  int          m_sat;
  bit          rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(input longint acc, input longint bias, input int shift,
                                        input bit relu, output bit sat);
    longint s;
    int     sh;
    logic [63:0] t;
    s  = acc + bias;
    sh = (shift > 20) ? 20 : shift;
    if (relu && s < 0) s = 0;
    if (sh > 0) s = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    sat = (s > 127) || (s < -128);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    t = s;
    return t[7:0];
  endfunction

  task automatic model_push(input int acc, input int bias, input int sh, input bit relu, input bit last);
    bit          sat;
    logic [7:0]  q;
    q = ref_q(acc, bias, sh, relu, sat);
    if (sat && m_sat < 65535) m_sat++;
    m_word[m_n*8 +: 8] = q;
    m_mask[m_n] = 1'b1;
    m_n++;
    if (m_n == PACK || last) begin
      exp_data.push_back(m_word);
      exp_mask.push_back(m_mask);
      m_word = '0;
      m_mask = '0;
      m_n    = 0;
    end
  endtask

  task automatic model_reset();
    m_word = '0;
    m_mask = '0;
    m_n    = 0;
    m_sat  = 0;
    exp_data.delete();
    exp_mask.delete();
  endtask

  // Entered and left just after a rising edge; the handshake edge is the one following a ready negedge.
  task automatic send(input int acc, input int bias, input int sh, input bit relu, input bit last);
    int waitc = 0;
    i_acc_valid  = 1'b1;
    i_acc_kernel = acc[19:0];
    i_bias       = bias[15:0];
    i_shift      = sh[4:0];
    i_relu_en    = relu;
    i_last       = last;
    @(negedge clk);
    while (!o_acc_ready && waitc < 200) begin
      waitc++;
      @(negedge clk);
    end
    if (!o_acc_ready) begin
      chk("send_timeout", 64'd1, 64'd0);
      i_acc_valid = 1'b0;
      return;
    end
    model_push(acc, bias, sh, relu, last);
    @(posedge clk);
    #1;
    i_acc_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (exp_data.size() != 0 && c < 1000) begin
      c++;
      cycles(1);
    end
    cycles(6);
    chk(name, 64'(exp_data.size()), 64'd0);
  endtask

  // Output monitor: a word transfers on the rising edge after a negedge that sees valid & ready.
  always @(negedge clk) begin
    if (!rst_n && o_pack_valid && i_pack_ready) begin
      if (exp_data.size() == 0) begin
        chk("unexpected_word", 64'(o_pack_data), 64'hDEAD_BEEF_0000_0000);
      end else begin
        chk("word_data", 64'(o_pack_data), 64'(exp_data.pop_front()));
        chk("word_mask", 64'(o_pack_mask), 64'(exp_mask.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) i_pack_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] held;
    logic [19:0] ra;
    logic [15:0] rb;
    int acc, bias;

    rst_n = 1'b1; i_acc_valid = 1'b0; i_acc_kernel = '0; i_bias = '0;
    i_shift = '0; i_relu_en = 1'b0; i_last = 1'b0; i_pack_ready = 1'b1;
    model_reset();
    cycles(3);
    chk("rst_valid", 64'(o_pack_valid), 64'd0);
    chk("rst_data", 64'(o_pack_data), 64'd0);
    chk("rst_mask", 64'(o_pack_mask), 64'd0);
    chk("rst_sat", 64'(o_sat_cnt), 64'd0);
    rst_n = 1'b0;
    cycles(1);

    // Case 1: four identical elements, latency of three edges
    for (int i = 0; i < 4; i++) send(100, -4, 2, 1'b0, i == 3);
    cycles(2);
    chk("lat_not_yet", 64'(o_pack_valid), 64'd0);
    cycles(1);
    chk("lat_valid", 64'(o_pack_valid), 64'd1);
    chk("t1_data", 64'(o_pack_data), 64'h1818_1818);
    drain("t1_drain");

    // Case 2: ReLU clamp and negative rounding
    send(-300, 0, 0, 1'b1, 1'b0);
    send(-6, 0, 2, 1'b0, 1'b1);
    drain("t2_drain");

    // Case 3: saturation both ways
    send(1000, 0, 0, 1'b0, 1'b0);
    send(-1000, 0, 0, 1'b0, 1'b1);
    drain("t3_drain");
    chk("t3_sat_cnt", 64'(o_sat_cnt), 64'd2);

    // Case 4: back-pressure hold
    i_pack_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 0, 0, 1'b0, 1'b0);
    cycles(3);
    chk("t4_valid", 64'(o_pack_valid), 64'd1);
    chk("t4_data", 64'(o_pack_data), 64'h0403_0201);
    held = o_pack_data;
    for (int i = 0; i < 5; i++) begin
      chk("t4_ready_low", 64'(o_acc_ready), 64'd0);
      chk("t4_hold", 64'(o_pack_data), 64'(held));
      cycles(1);
    end
    i_pack_ready = 1'b1;
    drain("t4_drain");

    // Case 5: reset discards a partial word
    send(9, 0, 0, 1'b0, 1'b0);
    send(10, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
    cycles(1);
    rst_n = 1'b0;
    chk("t5_rst_valid", 64'(o_pack_valid), 64'd0);
    chk("t5_rst_sat", 64'(o_sat_cnt), 64'd0);
    for (int i = 5; i <= 8; i++) send(i, 0, 0, 1'b0, 1'b0);
    cycles(3);
    chk("t5_data", 64'(o_pack_data), 64'h0807_0605);
    drain("t5_drain");

    // Case 6: randomized traffic with stalls on both sides
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) cycles(1);
      ra = 20'($urandom);
      rb = 16'($urandom);
      acc  = int'($signed(ra));
      bias = int'($signed(rb));
      if ($urandom_range(0, 1) == 1) acc  = int'($urandom_range(0, 2000)) - 1000;
      if ($urandom_range(0, 1) == 1) bias = int'($urandom_range(0, 64)) - 32;
      send(acc, bias, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           (i == 999) || ($urandom_range(0, 7) == 0));
    end
    drain("t6_drain");
    rdy_rand = 1'b0;
    i_pack_ready = 1'b1;
    cycles(2);
    chk("t6_sat_cnt", 64'(o_sat_cnt), 64'(m_sat));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
